dmem_resp: RTL
==============

# dmem_resp

Data-memory responder on the core's load/store port. It samples the memory stage's request each cycle:
- stores go into a byte-lane RAM;
- loads return aligned, sign- or zero-extended data one cycle later, in time for write-back.

It also detects misaligned and reserved-type accesses, suppresses them, and records the first one in a sticky error register.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit words; power of two.
- ADDR_W, 32: request address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_addr  in  ADDR_W  byte address of the load or store.
- mem_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- mem_type  in  2  access size: `MEM_B=2'b00, `MEM_H=2'b01, `MEM_W=2'b10, 2'b11 reserved.
- mem_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- rmem  in  1  load request this cycle.
- wmem  in  1  store request this cycle.
- mem_rdata  out  32  extended load data.
- err  out  1  sticky access-error flag.
- err_addr  out  ADDR_W  mem_addr of the first error since the last clear.
- err_clr  in  1  clears err and err_addr.

## Operation
- **Word index:** mem_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- **Byte offset:** off = mem_addr[1:0].
- **Legal requests:**
  - B: any off.
  - H: off ∈ {0,2}.
  - W: off = 0.
  - Type 2'b11 is always illegal.
- **Store (wmem=1, legal):** writes bytes at the edge using byte enables.
  - B: byte lane off ← wdata[7:0].
  - H: lanes off and off+1 ← wdata[15:0].
  - W: all four lanes ← wdata.
- **Load (rmem=1, legal):** the edge registers these into a load-context register, together with the raw RAM word (synchronous read):
  - off;
  - type;
  - sign.
- **mem_rdata** is formed from the raw word and the context:
  - B: selected byte, extended from bit 7.
  - H: selected half, extended from bit 15.
  - W: word unchanged.
  - Extension uses sign when mem_sign=1, zeros otherwise.
- **Hold:** mem_rdata changes only after a load edge. Otherwise it holds the last load result.
- **Illegal request (rmem or wmem, illegal):**
  - No RAM write.
  - On a load, the context is forced so that mem_rdata = 0 next cycle.
  - err ← 1. err_addr ← mem_addr only if err was 0 (first error kept).
- **rmem and wmem both high:** legal request; the store is performed and the load returns the pre-write word (read-first).
- **Neither asserted:** no state change except err_clr.
- **err_clr=1:** err ← 0, err_addr ← 0. If an illegal request occurs in the same cycle, the error is recorded (set wins).
- **RAM contents:** not reset. An optional $readmemh init lives in the sub-module.

## Timing
- Reset values: mem_rdata = 0, err = 0, err_addr = 0, load context = {off 0, W, unsigned}.
- **Load latency:** request in cycle t, mem_rdata valid in cycle t+1, stable until the next load.
- **Store visibility:** a store in cycle t is committed at the end of t. A load in t+1 to the same address returns the new data, with no hazard bubble needed.
- **Reset during operation:**
  - Any request in the same cycle as rst=1 is dropped.
  - RAM keeps already-committed writes.
  - Outputs return to reset values immediately (asynchronous).
- No back-pressure. The responder accepts one request per cycle, every cycle.

## Structure
- The `MEM_B/H/W` codes and `mem_type_bus` width belong in the shared defines.v, next to `RegBus`.
- Sub-module dmem_ram:
  - DEPTH_WORDS × 32 array;
  - 4-bit byte-write enable;
  - registered read port;
  - read-first on collision.
- dmem_resp contains:
  - legality check;
  - byte-enable and lane-shift logic;
  - load-context register;
  - extension mux;
  - error register.

## Test plan
- **Word store/load:** W store 0xDEADBEEF @0x100, then W load @0x100 → mem_rdata = 0xDEADBEEF one cycle after rmem; err = 0.
- **Byte lanes:**
  - B store 0x80 @0x103 onto word 0x00000000.
  - Signed B load @0x103 → 0xFFFFFF80.
  - Unsigned B load @0x103 → 0x00000080.
  - W load @0x100 → 0x80000000.
- **Half-word:** H store 0x8001 @0x202. Signed H load @0x202 → 0xFFFF8001. Unsigned H load @0x200 → 0x00000000.
- **Misaligned, then clear:**
  - W store @0x105 → no write (W load @0x104 unchanged), err = 1, err_addr = 0x105.
  - Then H load @0x301 → mem_rdata = 0, err_addr still 0x105.
  - err_clr alone → err = 0.
  - err_clr together with a type-11 load @0x40 → err = 1, err_addr = 0x40.
- **Collision and wrap:**
  - rmem + wmem together, W @0x0, old 0x11111111, new 0x22222222 → mem_rdata = 0x11111111. A following load → 0x22222222.
  - With DEPTH_WORDS = 4096, a store @0x4000 → a load @0x0 returns it.
- **Async reset mid-stream:**
  - Assert rst between a load request and its response → mem_rdata = 0 immediately, and the pending load is lost.
  - After release, a load of the earlier committed address returns its stored data.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared access-type codes, bus widths, load-context payload
// and the legality/extension helpers used by the data-memory responder.
package dmem_resp_pkg;

    localparam int unsigned REG_BUS_W      = 32;
    localparam int unsigned MEM_TYPE_BUS_W = 2;
    localparam int unsigned LANES          = REG_BUS_W / 8;

    typedef enum logic [MEM_TYPE_BUS_W-1:0] {
        MEM_B   = 2'b00,
        MEM_H   = 2'b01,
        MEM_W   = 2'b10,
        MEM_RSV = 2'b11
    } mem_type_e;

    // Everything the extension mux needs to shape the raw word one cycle later.
    typedef struct packed {
        logic [1:0] off;
        mem_type_e  typ;
        logic       sgn;
    } load_ctx_t;

    localparam load_ctx_t LOAD_CTX_RST = '{off: 2'd0, typ: MEM_W, sgn: 1'b0};

    // Natural alignment check; the reserved type is never legal.
    function automatic logic access_legal(input mem_type_e typ, input logic [1:0] off);
        case (typ)
            MEM_B:   return 1'b1;
            MEM_H:   return ~off[0];
            MEM_W:   return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Select the addressed byte/half of the raw word and extend it to 32 bits.
    function automatic logic [REG_BUS_W-1:0] load_extend(input logic [REG_BUS_W-1:0] raw,
                                                         input load_ctx_t ctx);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{ctx.off, 3'b000} +: 8];
        h = ctx.off[1] ? raw[31:16] : raw[15:0];
        case (ctx.typ)
            MEM_B:   return {{24{ctx.sgn & b[7]}}, b};
            MEM_H:   return {{16{ctx.sgn & h[15]}}, h};
            MEM_W:   return raw;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH_WORDS x 32 byte-lane RAM with a registered read port.
//   clk, rst   : clock, async active-high reset (read register only)
//   idx_i      : word index shared by read and write
//   be_i       : per-lane write enables
//   wdata_i    : lane-aligned write data
//   rd_en_i    : capture the addressed word into the read register
//   rd_clr_i   : force the read register to zero
//   rdata_o    : registered read data (old word on a same-cycle write)
module dmem_ram
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [LANES-1:0]     be_i,
    input  logic [REG_BUS_W-1:0] wdata_i,
    input  logic                 rd_en_i,
    input  logic                 rd_clr_i,
    output logic [REG_BUS_W-1:0] rdata_o
);

    logic [REG_BUS_W-1:0] mem_q [DEPTH_WORDS];
    logic [REG_BUS_W-1:0] rdata_q;

    // Array contents are not reset; each lane is written independently.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(LANES); b++) begin
            if (be_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Non-blocking read of the array gives read-first on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_clr_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder on the core load/store port.
//   clk, rst   : clock, async active-high reset
//   mem_addr   : byte address of the request
//   mem_wdata  : right-aligned store data
//   mem_type   : access size (B/H/W, 2'b11 reserved)
//   mem_sign   : sign-extend loads when set
//   rmem, wmem : load / store request strobes
//   mem_rdata  : extended load data, valid the cycle after the load
//   err        : sticky access-error flag
//   err_addr   : address of the first error since the last clear
//   err_clr    : clears err and err_addr (a same-cycle error still records)
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [REG_BUS_W-1:0] mem_wdata,
    input  logic [1:0]           mem_type,
    input  logic                 mem_sign,
    input  logic                 rmem,
    input  logic                 wmem,
    output logic [REG_BUS_W-1:0] mem_rdata,
    output logic                 err,
    output logic [ADDR_W-1:0]    err_addr,
    input  logic                 err_clr
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [IDX_W-1:0]     idx_c;
    logic [1:0]           off_c;
    mem_type_e            typ_c;
    logic                 legal_c;
    logic                 bad_c;
    logic [LANES-1:0]     be_c;
    logic [LANES-1:0]     ram_be_c;
    logic [REG_BUS_W-1:0] wlane_c;
    logic [REG_BUS_W-1:0] raw_c;
    logic                 rd_en_c;
    logic                 rd_clr_c;
    logic                 unused_addr_c;

    load_ctx_t            ctx_q, ctx_d;
    logic                 err_q, err_d;
    logic [ADDR_W-1:0]    err_addr_q, err_addr_d;

    // Address decode; bits above the word index wrap away.
    assign idx_c         = mem_addr[IDX_W+1:2];
    assign off_c         = mem_addr[1:0];
    assign typ_c         = mem_type_e'(mem_type);
    assign unused_addr_c = ^mem_addr[ADDR_W-1:IDX_W+2];

    assign legal_c  = access_legal(typ_c, off_c);
    assign bad_c    = (rmem | wmem) & ~legal_c;
    assign rd_en_c  = rmem & legal_c;
    assign rd_clr_c = rmem & ~legal_c;

    // Byte enables and lane replication so every enabled lane sees its data.
    always_comb begin
        be_c    = '0;
        wlane_c = mem_wdata;
        case (typ_c)
            MEM_B: begin
                be_c    = LANES'(4'b0001 << off_c);
                wlane_c = {4{mem_wdata[7:0]}};
            end
            MEM_H: begin
                be_c    = LANES'(4'b0011 << off_c);
                wlane_c = {2{mem_wdata[15:0]}};
            end
            MEM_W: begin
                be_c    = 4'b1111;
                wlane_c = mem_wdata;
            end
            default: begin
                be_c    = '0;
                wlane_c = mem_wdata;
            end
        endcase
    end

    // Requests coinciding with reset must not reach the array.
    assign ram_be_c = (wmem && legal_c && !rst) ? be_c : '0;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .idx_i    (idx_c),
        .be_i     (ram_be_c),
        .wdata_i  (wlane_c),
        .rd_en_i  (rd_en_c),
        .rd_clr_i (rd_clr_c),
        .rdata_o  (raw_c)
    );

    // Load context follows every load; an illegal load parks it on an unsigned
    // word so the zeroed raw register yields mem_rdata = 0.
    always_comb begin
        ctx_d = ctx_q;
        if (rmem) begin
            if (legal_c) begin
                ctx_d = '{off: off_c, typ: typ_c, sgn: mem_sign};
            end else begin
                ctx_d = LOAD_CTX_RST;
            end
        end
    end

    // Sticky error: clear first, then a same-cycle error records over it.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
        if (bad_c) begin
            err_d = 1'b1;
            if (!err_q || err_clr) begin
                err_addr_d = mem_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_q      <= LOAD_CTX_RST;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            ctx_q      <= ctx_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign mem_rdata = load_extend(raw_c, ctx_q);
    assign err       = err_q;
    assign err_addr  = err_addr_q;

endmodule
